// File: rtl/iob_fifo_sync_tdp.sv
// Synchronous FIFO controller driving an external true-dual-port RAM.
// Port A carries FIFO writes, port B carries FIFO reads; storage lives outside.
module iob_fifo_sync_tdp #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 4,
   parameter int ALM_FULL_TH  = 2**ADDR_W - 2,
   parameter int ALM_EMPTY_TH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              w_en,
   input  logic [DATA_W-1:0] w_data,
   output logic              w_full,
   output logic              w_almost_full,
   input  logic              r_en,
   output logic [DATA_W-1:0] r_data,
   output logic              r_valid,
   output logic              r_empty,
   output logic              r_almost_empty,
   output logic [ADDR_W:0]   level,
   output logic              overflow,
   output logic              underflow,
   output logic              ext_mem_w_en,
   output logic [ADDR_W-1:0] ext_mem_w_addr,
   output logic [DATA_W-1:0] ext_mem_w_data,
   output logic              ext_mem_r_en,
   output logic [ADDR_W-1:0] ext_mem_r_addr,
   input  logic [DATA_W-1:0] ext_mem_r_data
);

   localparam logic [ADDR_W:0] DEPTH         = (ADDR_W+1)'(2**ADDR_W);
   localparam logic [ADDR_W:0] ALM_FULL_LVL  = (ADDR_W+1)'(ALM_FULL_TH);
   localparam logic [ADDR_W:0] ALM_EMPTY_LVL = (ADDR_W+1)'(ALM_EMPTY_TH);

   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [ADDR_W-1:0] rptr_q, rptr_d;
   logic [ADDR_W:0]   level_q, level_d;
   logic              r_valid_q, r_valid_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic              w_acc, r_acc;

   // Flags come only from the registered level, so no request-to-flag path exists.
   assign w_full         = (level_q == DEPTH);
   assign r_empty        = (level_q == '0);
   assign w_almost_full  = (level_q >= ALM_FULL_LVL);
   assign r_almost_empty = (level_q <= ALM_EMPTY_LVL);

   // Requests during reset must not reach the RAM.
   assign w_acc = w_en & ~w_full & ~rst;
   assign r_acc = r_en & ~r_empty & ~rst;

   assign ext_mem_w_en   = w_acc;
   assign ext_mem_w_addr = wptr_q;
   assign ext_mem_w_data = w_data;
   assign ext_mem_r_en   = r_acc;
   assign ext_mem_r_addr = rptr_q;

   assign r_data    = ext_mem_r_data;
   assign r_valid   = r_valid_q;
   assign level     = level_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      level_d     = level_q;
      r_valid_d   = r_acc;
      overflow_d  = overflow_q | (w_en & w_full);
      underflow_d = underflow_q | (r_en & r_empty);
      if (w_acc) wptr_d = wptr_q + 1'b1;
      if (r_acc) rptr_d = rptr_q + 1'b1;
      case ({w_acc, r_acc})
         2'b10:   level_d = level_q + (ADDR_W+1)'(1);
         2'b01:   level_d = level_q - (ADDR_W+1)'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         level_q     <= '0;
         r_valid_q   <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         level_q     <= level_d;
         r_valid_q   <= r_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

endmodule

// File: tb/tb_iob_fifo_sync_tdp.sv
// Bench for iob_fifo_sync_tdp: external RAM model, queue-based FIFO reference
// checked every cycle, and directed sequences with literal expectations.
module tb_iob_fifo_sync_tdp;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              w_en = 1'b0;
   logic [DATA_W-1:0] w_data = '0;
   logic              r_en = 1'b0;
   logic              w_full, w_almost_full, r_valid, r_empty, r_almost_empty;
   logic              overflow, underflow;
   logic [DATA_W-1:0] r_data;
   logic [ADDR_W:0]   level;
   logic              ext_mem_w_en, ext_mem_r_en;
   logic [ADDR_W-1:0] ext_mem_w_addr, ext_mem_r_addr;
   logic [DATA_W-1:0] ext_mem_w_data, ext_mem_r_data;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en = 1'b0;

   iob_fifo_sync_tdp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .w_en(w_en), .w_data(w_data), .w_full(w_full), .w_almost_full(w_almost_full),
      .r_en(r_en), .r_data(r_data), .r_valid(r_valid), .r_empty(r_empty),
      .r_almost_empty(r_almost_empty), .level(level),
      .overflow(overflow), .underflow(underflow),
      .ext_mem_w_en(ext_mem_w_en), .ext_mem_w_addr(ext_mem_w_addr),
      .ext_mem_w_data(ext_mem_w_data), .ext_mem_r_en(ext_mem_r_en),
      .ext_mem_r_addr(ext_mem_r_addr), .ext_mem_r_data(ext_mem_r_data)
   );

   always #5 clk = ~clk;

   // Dual-port RAM with registered read port
   logic [DATA_W-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (ext_mem_w_en) mem[ext_mem_w_addr] <= ext_mem_w_data;
      if (ext_mem_r_en) ext_mem_r_data <= mem[ext_mem_r_addr];
   end

   // Reference FIFO: a queue plus sticky error bits and transfer counters
   logic [DATA_W-1:0] m_q [$];
   logic [DATA_W-1:0] m_data = '0;
   bit m_valid = 0, m_ovf = 0, m_unf = 0;
   int m_wcnt = 0, m_rcnt = 0;
   always @(posedge clk) begin
      bit wa, ra;
      if (rst) begin
         m_q.delete();
         m_valid = 0; m_ovf = 0; m_unf = 0; m_wcnt = 0; m_rcnt = 0;
      end else begin
         wa = w_en && (m_q.size() < DEPTH);
         ra = r_en && (m_q.size() > 0);
         if (w_en && m_q.size() == DEPTH) m_ovf = 1;
         if (r_en && m_q.size() == 0) m_unf = 1;
         m_valid = ra;
         if (ra) begin m_data = m_q.pop_front(); m_rcnt++; end
         if (wa) begin m_q.push_back(w_data); m_wcnt++; end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the reference
   always @(negedge clk) begin
      if (chk_en) begin
         int sz;
         sz = m_q.size();
         checkOutput("level", 64'(level), 64'(sz));
         checkOutput("w_full", 64'(w_full), 64'(sz == DEPTH));
         checkOutput("r_empty", 64'(r_empty), 64'(sz == 0));
         checkOutput("w_almost_full", 64'(w_almost_full), 64'(sz >= DEPTH - 2));
         checkOutput("r_almost_empty", 64'(r_almost_empty), 64'(sz <= 2));
         checkOutput("r_valid", 64'(r_valid), 64'(m_valid));
         checkOutput("overflow", 64'(overflow), 64'(m_ovf));
         checkOutput("underflow", 64'(underflow), 64'(m_unf));
         checkOutput("ext_mem_w_en", 64'(ext_mem_w_en), 64'(!rst && w_en && sz < DEPTH));
         checkOutput("ext_mem_r_en", 64'(ext_mem_r_en), 64'(!rst && r_en && sz > 0));
         checkOutput("ext_mem_w_addr", 64'(ext_mem_w_addr), 64'(m_wcnt % DEPTH));
         checkOutput("ext_mem_r_addr", 64'(ext_mem_r_addr), 64'(m_rcnt % DEPTH));
         if (ext_mem_w_en) checkOutput("ext_mem_w_data", 64'(ext_mem_w_data), 64'(w_data));
         if (m_valid) checkOutput("r_data", 64'(r_data), 64'(m_data));
      end
   end

   task automatic applyStimulus(input bit we, input logic [DATA_W-1:0] wd, input bit re, input bit rs);
      @(posedge clk);
      #1;
      w_en = we; w_data = wd; r_en = re; rst = rs;
   endtask

   initial begin
      // Reset then idle
      applyStimulus(1, 32'hDEAD, 1, 1);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0);
      chk_en = 1'b1;
      @(negedge clk);
      checkOutput("rst_level", 64'(level), 64'd0);
      checkOutput("rst_r_empty", 64'(r_empty), 64'd1);
      checkOutput("rst_w_full", 64'(w_full), 64'd0);
      checkOutput("rst_r_valid", 64'(r_valid), 64'd0);
      checkOutput("rst_errors", 64'({overflow, underflow}), 64'd0);
      checkOutput("rst_enables", 64'({ext_mem_w_en, ext_mem_r_en}), 64'd0);

      // Fill 16 words
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1, DATA_W'(i), 0, 0);
         @(negedge clk);
         checkOutput("fill_level", 64'(level), 64'(i));
         checkOutput("fill_almost_full", 64'(w_almost_full), 64'(i >= 14));
         checkOutput("fill_full", 64'(w_full), 64'd0);
      end
      applyStimulus(1, 32'h55, 0, 0);
      @(negedge clk);
      checkOutput("full_level", 64'(level), 64'd16);
      checkOutput("full_flag", 64'(w_full), 64'd1);
      checkOutput("full_w_en_blocked", 64'(ext_mem_w_en), 64'd0);
      applyStimulus(0, 0, 0, 0);
      @(negedge clk);
      checkOutput("overflow_set", 64'(overflow), 64'd1);
      checkOutput("overflow_level", 64'(level), 64'd16);

      // Drain 16 words in order
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(0, 0, 1, 0);
         @(negedge clk);
         checkOutput("drain_level", 64'(level), 64'(DEPTH - i));
         checkOutput("drain_r_valid", 64'(r_valid), 64'(i > 0));
         if (i > 0) checkOutput("drain_r_data", 64'(r_data), 64'(i - 1));
      end
      applyStimulus(0, 0, 1, 0);
      @(negedge clk);
      checkOutput("last_r_data", 64'(r_data), 64'd15);
      checkOutput("last_r_valid", 64'(r_valid), 64'd1);
      checkOutput("empty_after_drain", 64'(r_empty), 64'd1);
      applyStimulus(0, 0, 0, 0);
      @(negedge clk);
      checkOutput("underflow_set", 64'(underflow), 64'd1);
      checkOutput("underflow_r_valid", 64'(r_valid), 64'd0);

      // Simultaneous request while empty: write wins, read rejected
      applyStimulus(1, 32'h77, 1, 0);
      applyStimulus(0, 0, 0, 0);
      @(negedge clk);
      checkOutput("sim_empty_level", 64'(level), 64'd1);
      checkOutput("sim_empty_r_valid", 64'(r_valid), 64'd0);
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0);
      @(negedge clk);
      checkOutput("sim_empty_data", 64'(r_data), 64'h77);

      // Pointer wrap: 10/10 then 12/12
      for (int i = 0; i < 10; i++) applyStimulus(1, 32'hA00 + DATA_W'(i), 0, 0);
      for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 0);
      for (int i = 0; i < 12; i++) applyStimulus(1, 32'hB00 + DATA_W'(i), 0, 0);
      for (int i = 0; i < 12; i++) applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0);
      @(negedge clk);
      checkOutput("wrap_level", 64'(level), 64'd0);
      checkOutput("wrap_last_data", 64'(r_data), 64'hB0B);

      // Sustained write+read at level 5
      for (int i = 0; i < 5; i++) applyStimulus(1, 32'h100 + DATA_W'(i), 0, 0);
      for (int k = 0; k < 20; k++) begin
         applyStimulus(1, 32'h200 + DATA_W'(k), 1, 0);
         @(negedge clk);
         checkOutput("stream_level", 64'(level), 64'd5);
         if (k > 0)
            checkOutput("stream_data", 64'(r_data),
                        (k - 1 < 5) ? 64'(32'h100 + k - 1) : 64'(32'h200 + k - 6));
      end
      // Top up to full, then simultaneous request while full
      for (int i = 0; i < 11; i++) applyStimulus(1, 32'h300 + DATA_W'(i), 0, 0);
      applyStimulus(1, 32'h3FF, 1, 0);
      applyStimulus(0, 0, 0, 0);
      @(negedge clk);
      checkOutput("sim_full_level", 64'(level), 64'd15);
      checkOutput("sim_full_overflow", 64'(overflow), 64'd1);
      checkOutput("sim_full_data", 64'(r_data), 64'h20F);
      for (int i = 0; i < 15; i++) applyStimulus(0, 0, 1, 0);

      // Reset at level 7 with both requests active
      for (int i = 0; i < 7; i++) applyStimulus(1, 32'h400 + DATA_W'(i), 0, 0);
      applyStimulus(1, 32'h4FF, 1, 1);
      @(negedge clk);
      checkOutput("rst_mid_w_en", 64'(ext_mem_w_en), 64'd0);
      checkOutput("rst_mid_r_en", 64'(ext_mem_r_en), 64'd0);
      applyStimulus(0, 0, 0, 0);
      @(negedge clk);
      checkOutput("rst_mid_level", 64'(level), 64'd0);
      checkOutput("rst_mid_empty", 64'(r_empty), 64'd1);
      checkOutput("rst_mid_r_valid", 64'(r_valid), 64'd0);
      checkOutput("rst_mid_errors", 64'({overflow, underflow}), 64'd0);
      applyStimulus(1, 32'hABC, 0, 0);
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0);
      @(negedge clk);
      checkOutput("post_rst_valid", 64'(r_valid), 64'd1);
      checkOutput("post_rst_data", 64'(r_data), 64'hABC);
      applyStimulus(0, 0, 0, 0);
      @(negedge clk);
      checkOutput("post_rst_empty", 64'(r_empty), 64'd1);

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
